// File: rtl/mem_port_pkg.sv
// Shared types and constants for the unified instruction/data memory port.
package mem_port_pkg;

    localparam int unsigned ADDR_W_DEF  = 32;
    localparam int unsigned DATA_W_DEF  = 32;
    localparam int unsigned TIMEOUT_DEF = 255;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } state_e;

    // Attributes of the transaction captured in IDLE.
    typedef struct packed {
        logic write;
        logic to_ir;
    } req_kind_t;

    // RISC-V base opcodes shared with the control FSM.
    localparam logic [6:0] LOAD   = 7'b0000011;
    localparam logic [6:0] STORE  = 7'b0100011;
    localparam logic [6:0] OP     = 7'b0110011;
    localparam logic [6:0] OP_IMM = 7'b0010011;
    localparam logic [6:0] BRANCH = 7'b1100011;
    localparam logic [6:0] JAL    = 7'b1101111;

    // Word accesses only: any nonzero low address bit is an error.
    function automatic logic is_misaligned(input logic [1:0] lsb);
        return lsb != 2'b00;
    endfunction

endpackage

// File: rtl/mem_port_timeout.sv
// Saturating watchdog counter; expired_c flags the cycle that reaches TIMEOUT.
module mem_port_timeout #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic expired_c
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    // Clear has priority; otherwise count while enabled, saturating at TIMEOUT.
    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (en && (count_q != CNT_MAX)) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    // The edge that would bring the count to TIMEOUT is the expiry edge.
    assign expired_c = en && !clr && (count_q == CNT_LAST);

    // Counter register.
    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/mem_port_unit.sv
// Unified IR/MDR memory port: address select, valid/ready request, result latch.
module mem_port_unit
    import mem_port_pkg::*;
#(
    parameter int unsigned ADDR_W  = ADDR_W_DEF,
    parameter int unsigned DATA_W  = DATA_W_DEF,
    parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              memRead,
    input  logic              memWrite,
    input  logic              memGetData,
    input  logic              irWrite,
    input  logic [ADDR_W-1:0] pc,
    input  logic [ADDR_W-1:0] aluOut,
    input  logic [DATA_W-1:0] storeData,
    output logic              memReqValid,
    input  logic              memReqReady,
    output logic              memReqWrite,
    output logic [ADDR_W-1:0] memReqAddr,
    output logic [DATA_W-1:0] memReqWdata,
    input  logic              memRespValid,
    input  logic [DATA_W-1:0] memRespData,
    output logic [DATA_W-1:0] instr,
    output logic [6:0]        opcode,
    output logic [DATA_W-1:0] mdr,
    output logic              stall,
    output logic              err
);

    state_e            state_q,     state_d;
    logic              req_valid_q, req_valid_d;
    req_kind_t         kind_q,      kind_d;
    logic [ADDR_W-1:0] req_addr_q,  req_addr_d;
    logic [DATA_W-1:0] req_wdata_q, req_wdata_d;
    logic [DATA_W-1:0] instr_q,     instr_d;
    logic [DATA_W-1:0] mdr_q,       mdr_d;
    logic              err_q,       err_d;

    logic [ADDR_W-1:0] addr_sel_c;
    logic              to_clr_c;
    logic              to_en_c;
    logic              to_expired_c;

    assign addr_sel_c = memGetData ? aluOut : pc;

    // Watchdog restarts in IDLE (entry to REQ) and on every REQ->WAIT handoff.
    assign to_clr_c = (state_q == IDLE) || ((state_q == REQ) && memReqReady);
    assign to_en_c  = (state_q != IDLE);

    mem_port_timeout #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .clk       (clk),
        .reset     (reset),
        .clr       (to_clr_c),
        .en        (to_en_c),
        .expired_c (to_expired_c)
    );

    // Next-state and register-update logic for the request FSM.
    always_comb begin
        state_d     = state_q;
        req_valid_d = req_valid_q;
        kind_d      = kind_q;
        req_addr_d  = req_addr_q;
        req_wdata_d = req_wdata_q;
        instr_d     = instr_q;
        mdr_d       = mdr_q;
        err_d       = err_q;

        unique case (state_q)
            IDLE: begin
                if (memRead || memWrite) begin
                    req_addr_d   = addr_sel_c;
                    req_wdata_d  = storeData;
                    kind_d.write = memWrite;
                    kind_d.to_ir = irWrite;
                    if ((memRead && memWrite) || is_misaligned(addr_sel_c[1:0])) begin
                        err_d = 1'b1;
                    end else begin
                        state_d     = REQ;
                        req_valid_d = 1'b1;
                    end
                end
            end
            REQ: begin
                // A handshake on the expiry edge still completes the request.
                if (memReqReady) begin
                    req_valid_d = 1'b0;
                    state_d     = kind_q.write ? IDLE : WAIT;
                end else if (to_expired_c) begin
                    req_valid_d = 1'b0;
                    err_d       = 1'b1;
                    state_d     = IDLE;
                end
            end
            WAIT: begin
                if (memRespValid) begin
                    if (kind_q.to_ir) begin
                        instr_d = memRespData;
                    end else begin
                        mdr_d = memRespData;
                    end
                    state_d = IDLE;
                end else if (to_expired_c) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d     = IDLE;
                req_valid_d = 1'b0;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            req_valid_q <= 1'b0;
            kind_q      <= '0;
            req_addr_q  <= '0;
            req_wdata_q <= '0;
            instr_q     <= '0;
            mdr_q       <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            req_valid_q <= req_valid_d;
            kind_q      <= kind_d;
            req_addr_q  <= req_addr_d;
            req_wdata_q <= req_wdata_d;
            instr_q     <= instr_d;
            mdr_q       <= mdr_d;
            err_q       <= err_d;
        end
    end

    assign memReqValid = req_valid_q;
    assign memReqWrite = kind_q.write;
    assign memReqAddr  = req_addr_q;
    assign memReqWdata = req_wdata_q;
    assign instr       = instr_q;
    assign opcode      = instr_q[6:0];
    assign mdr         = mdr_q;
    assign err         = err_q;
    assign stall       = (state_q != IDLE);

endmodule

// File: tb/tb_mem_port_unit.sv
// Self-checking bench for mem_port_unit: directed table, hand sequences, random vs model.
module tb_mem_port_unit;
    import mem_port_pkg::*;

    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;
    localparam int unsigned TO = 8;

    logic          clk = 1'b0;
    logic          reset;
    logic          memRead, memWrite, memGetData, irWrite;
    logic [AW-1:0] pc, aluOut;
    logic [DW-1:0] storeData;
    logic          memReqValid, memReqReady, memReqWrite;
    logic [AW-1:0] memReqAddr;
    logic [DW-1:0] memReqWdata;
    logic          memRespValid;
    logic [DW-1:0] memRespData;
    logic [DW-1:0] instr, mdr;
    logic [6:0]    opcode;
    logic          stall, err;

    always #5 clk = ~clk;

    mem_port_unit #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset),
        .memRead(memRead), .memWrite(memWrite), .memGetData(memGetData), .irWrite(irWrite),
        .pc(pc), .aluOut(aluOut), .storeData(storeData),
        .memReqValid(memReqValid), .memReqReady(memReqReady), .memReqWrite(memReqWrite),
        .memReqAddr(memReqAddr), .memReqWdata(memReqWdata),
        .memRespValid(memRespValid), .memRespData(memRespData),
        .instr(instr), .opcode(opcode), .mdr(mdr), .stall(stall), .err(err)
    );

    typedef struct {
        logic        rd, wr, gd, irw;
        logic [31:0] pc, alu, sd;
        int          rdy, rsp;
        logic [31:0] rdata;
        logic [31:0] e_instr, e_mdr;
        logic        e_err;
        int          e_stall, e_acc;
        logic [31:0] e_addr;
        logic        e_write;
    } vec_t;

    int tests = 0;
    int fails = 0;

    // Model state for the randomized section.
    logic [31:0] m_instr, m_mdr;
    logic        m_err;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        memRead = 0; memWrite = 0; memGetData = 0; irWrite = 0;
        pc = '0; aluOut = '0; storeData = '0;
        memReqReady = 0; memRespValid = 0; memRespData = '0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    // Issue one request from IDLE and act as memory until stall falls (bounded).
    task automatic do_txn(input vec_t v, output int stall_cyc, output int acc,
                          output logic [31:0] a_addr, output logic a_write,
                          output logic [31:0] a_wdata, output int unstable);
        int req_n, wait_n;
        logic have_ref;
        logic [31:0] r_addr, r_wdata;
        logic r_write;
        memRead = v.rd; memWrite = v.wr; memGetData = v.gd; irWrite = v.irw;
        pc = v.pc; aluOut = v.alu; storeData = v.sd;
        @(posedge clk); #1;
        memRead = 0; memWrite = 0;
        pc = $urandom; aluOut = $urandom; storeData = $urandom;
        stall_cyc = 0; acc = 0; unstable = 0; req_n = 0; wait_n = 0; have_ref = 0;
        a_addr = '0; a_write = 0; a_wdata = '0;
        r_addr = '0; r_write = 0; r_wdata = '0;
        while (stall === 1'b1 && stall_cyc < 100) begin
            stall_cyc++;
            if (memReqValid === 1'b1) begin
                if (!have_ref) begin
                    have_ref = 1; r_addr = memReqAddr; r_write = memReqWrite; r_wdata = memReqWdata;
                end else if (memReqAddr !== r_addr || memReqWrite !== r_write || memReqWdata !== r_wdata) begin
                    unstable++;
                end
                memReqReady  = (req_n == v.rdy);
                // Stray responses while a request is pending must be ignored.
                memRespValid = $urandom_range(0, 1) == 1;
                memRespData  = $urandom;
                if (memReqReady) begin
                    acc++; a_addr = memReqAddr; a_write = memReqWrite; a_wdata = memReqWdata;
                end
                req_n++;
            end else begin
                memReqReady  = 0;
                memRespValid = (wait_n == v.rsp);
                memRespData  = memRespValid ? v.rdata : $urandom;
                wait_n++;
            end
            @(posedge clk); #1;
            memReqReady = 0; memRespValid = 0;
        end
    endtask

    task automatic run_check(input string name, input vec_t v);
        int sc, acc, unst;
        logic [31:0] aa, aw;
        logic awr;
        do_txn(v, sc, acc, aa, awr, aw, unst);
        check({name, ".stall_cycles"}, 64'(sc), 64'(v.e_stall));
        check({name, ".accepted"}, 64'(acc), 64'(v.e_acc));
        if (v.e_acc > 0) begin
            check({name, ".addr"}, 64'(aa), 64'(v.e_addr));
            check({name, ".write"}, 64'(awr), 64'(v.e_write));
            if (v.e_write) check({name, ".wdata"}, 64'(aw), 64'(v.sd));
        end
        check({name, ".req_stable"}, 64'(unst), 64'd0);
        check({name, ".valid_idle"}, 64'(memReqValid), 64'd0);
        check({name, ".instr"}, 64'(instr), 64'(v.e_instr));
        check({name, ".opcode"}, 64'(opcode), 64'(v.e_instr[6:0]));
        check({name, ".mdr"}, 64'(mdr), 64'(v.e_mdr));
        check({name, ".err"}, 64'(err), 64'(v.e_err));
    endtask

    task automatic check_reset_vals(input string name);
        check({name, ".instr"}, 64'(instr), 64'd0);
        check({name, ".mdr"}, 64'(mdr), 64'd0);
        check({name, ".err"}, 64'(err), 64'd0);
        check({name, ".stall"}, 64'(stall), 64'd0);
        check({name, ".valid"}, 64'(memReqValid), 64'd0);
        check({name, ".write"}, 64'(memReqWrite), 64'd0);
        check({name, ".addr"}, 64'(memReqAddr), 64'd0);
        check({name, ".wdata"}, 64'(memReqWdata), 64'd0);
    endtask

    // Reference: expected outcome from the port's rules, updating m_* state.
    function automatic vec_t model(input vec_t v);
        vec_t r = v;
        logic [31:0] addr = v.gd ? v.alu : v.pc;
        r.e_addr = addr; r.e_write = v.wr; r.e_acc = 0; r.e_stall = 0;
        if (!v.rd && !v.wr) begin
            // nothing happens
        end else if ((v.rd && v.wr) || addr[1:0] != 2'b00) begin
            m_err = 1;
        end else if (v.rdy >= int'(TO)) begin
            m_err = 1; r.e_stall = int'(TO);
        end else begin
            r.e_acc = 1;
            if (v.wr) r.e_stall = v.rdy + 1;
            else if (v.rsp >= int'(TO)) begin
                m_err = 1; r.e_stall = v.rdy + 1 + int'(TO);
            end else begin
                r.e_stall = v.rdy + v.rsp + 2;
                if (v.irw) m_instr = v.rdata; else m_mdr = v.rdata;
            end
        end
        r.e_instr = m_instr; r.e_mdr = m_mdr; r.e_err = m_err;
        return r;
    endfunction

    vec_t tbl[10];

    initial begin
        //             rd wr gd irw pc            alu           sd            rdy rsp rdata         e_instr       e_mdr         err stall acc addr         wr
        tbl[0] = '{1, 0, 0, 1, 32'h100, 32'h0,   32'h0,        0, 0, 32'h00A00093, 32'h00A00093, 32'h0,        0, 2,  1, 32'h100, 0};
        tbl[1] = '{1, 0, 1, 0, 32'h100, 32'h200, 32'h0,        3, 1, 32'hDEADBEEF, 32'h00A00093, 32'hDEADBEEF, 0, 6,  1, 32'h200, 0};
        tbl[2] = '{0, 1, 1, 0, 32'h100, 32'h204, 32'h12345678, 0, 0, 32'h0,        32'h00A00093, 32'hDEADBEEF, 0, 1,  1, 32'h204, 1};
        tbl[3] = '{1, 0, 0, 1, 32'h104, 32'h0,   32'h0,        1, 2, 32'h00000033, 32'h00000033, 32'hDEADBEEF, 0, 5,  1, 32'h104, 0};
        tbl[4] = '{1, 0, 1, 0, 32'h0,   32'h208, 32'h0,        7, 7, 32'hCAFEF00D, 32'h00000033, 32'hCAFEF00D, 0, 16, 1, 32'h208, 0};
        tbl[5] = '{0, 1, 1, 1, 32'h0,   32'h20C, 32'hA5A5A5A5, 2, 0, 32'h0,        32'h00000033, 32'hCAFEF00D, 0, 3,  1, 32'h20C, 1};
        tbl[6] = '{0, 0, 0, 0, 32'h110, 32'h0,   32'h0,        0, 0, 32'h0,        32'h00000033, 32'hCAFEF00D, 0, 0,  0, 32'h0,   0};
        tbl[7] = '{1, 0, 1, 0, 32'h0,   32'h202, 32'h0,        0, 0, 32'h11,       32'h00000033, 32'hCAFEF00D, 1, 0,  0, 32'h202, 0};
        tbl[8] = '{1, 0, 0, 1, 32'h108, 32'h0,   32'h0,        99, 0, 32'h0,       32'h00000033, 32'hCAFEF00D, 1, 8,  0, 32'h108, 0};
        tbl[9] = '{1, 0, 0, 0, 32'h10C, 32'h0,   32'h0,        0, 0, 32'h77,       32'h00000033, 32'h00000077, 1, 2,  1, 32'h10C, 0};

        do_reset();
        check_reset_vals("reset_init");

        for (int i = 0; i < 10; i++) run_check($sformatf("vec%0d", i), tbl[i]);
        check("vec3.opcode_is_OP", 64'(tbl[3].e_instr[6:0]), 64'(OP));

        // Reset clears sticky err and both result registers.
        do_reset();
        check_reset_vals("reset_after_err");

        // Simultaneous read and write is rejected.
        begin
            vec_t v = '{1, 1, 0, 0, 32'h40, 32'h0, 32'h0, 0, 0, 32'h0, 32'h0, 32'h0, 1, 0, 0, 32'h40, 0};
            run_check("rdwr_both", v);
        end

        // Timeout in WAIT, then a late response must not touch mdr.
        do_reset();
        begin
            vec_t v;
            v = '{1, 0, 1, 0, 32'h0, 32'h300, 32'h0, 0, 0, 32'h11111111, 32'h0, 32'h11111111, 0, 2, 1, 32'h300, 0};
            run_check("pre_timeout_load", v);
            v = '{1, 0, 1, 0, 32'h0, 32'h304, 32'h0, 0, 99, 32'h0, 32'h0, 32'h11111111, 1, 9, 1, 32'h304, 0};
            run_check("wait_timeout", v);
            memRespValid = 1; memRespData = 32'h22222222;
            @(posedge clk); #1;
            memRespValid = 0;
            check("late_resp.mdr", 64'(mdr), 64'h11111111);
            check("late_resp.instr", 64'(instr), 64'd0);
            check("late_resp.stall", 64'(stall), 64'd0);
        end

        // Reset while in WAIT aborts; a following response is ignored.
        do_reset();
        begin
            vec_t v = '{1, 0, 0, 1, 32'h400, 32'h0, 32'h0, 0, 0, 32'h00000013, 32'h00000013, 32'h0, 0, 2, 1, 32'h400, 0};
            run_check("pre_reset_fetch", v);
            check("pre_reset_fetch.opcode_is_OP_IMM", 64'(opcode), 64'(OP_IMM));
            memRead = 1; irWrite = 1; memGetData = 0; pc = 32'h404;
            @(posedge clk); #1;
            memRead = 0;
            memReqReady = 1;
            @(posedge clk); #1;
            memReqReady = 0;
            check("mid_wait.in_wait", 64'({stall, memReqValid}), 64'b10);
            reset = 1;
            @(posedge clk); #1;
            reset = 0;
            check_reset_vals("reset_mid_wait");
            memRespValid = 1; memRespData = 32'hFFFFFFFF;
            @(posedge clk); #1;
            memRespValid = 0;
            check("post_reset_resp.instr", 64'(instr), 64'd0);
            check("post_reset_resp.mdr", 64'(mdr), 64'd0);
            check("post_reset_resp.stall", 64'(stall), 64'd0);
        end

        // Randomized transactions against the reference model.
        for (int i = 0; i < 60; i++) begin
            vec_t v;
            int sel;
            if (i % 20 == 0) begin
                do_reset();
                m_instr = '0; m_mdr = '0; m_err = 0;
            end
            sel = int'($urandom_range(0, 15));
            v.rd  = (sel == 1) || (sel >= 2 && sel <= 9);
            v.wr  = (sel == 1) || (sel >= 10);
            v.gd  = $urandom_range(0, 1) == 1;
            v.irw = $urandom_range(0, 1) == 1;
            v.pc  = ($urandom & 32'hFFFF_FFFC) | (($urandom_range(0, 7) == 0) ? 32'($urandom_range(1, 3)) : 32'h0);
            v.alu = ($urandom & 32'hFFFF_FFFC) | (($urandom_range(0, 7) == 0) ? 32'($urandom_range(1, 3)) : 32'h0);
            v.sd  = $urandom;
            v.rdy = ($urandom_range(0, 9) == 0) ? int'($urandom_range(TO - 1, TO + 2)) : int'($urandom_range(0, 3));
            v.rsp = ($urandom_range(0, 9) == 0) ? int'($urandom_range(TO - 1, TO + 2)) : int'($urandom_range(0, 3));
            v.rdata = $urandom;
            v = model(v);
            run_check($sformatf("rand%0d", i), v);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/mem_port_unit.md
Name: mem_port_unit

Overview:
- Unified instruction/data memory port for the multi-cycle RISC-V datapath.
- Sits directly downstream of the control FSM. Consumes memRead, memWrite, memGetData and irWrite.
- Selects the address: PC for instruction fetch, ALUOut for load/store. Runs a valid/ready handshake to external memory.
- Latches results into the Instruction Register (IR) or Memory Data Register (MDR). Returns opcode and a stall flag to the control FSM.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width.
- TIMEOUT, 255, maximum number of cycles to wait for ready or response before aborting with an error.

Ports:
- clk, input, 1, clock; all state changes on the rising edge.
- reset, input, 1, synchronous active-high reset.
- memRead, input, 1, read request from control, sampled in IDLE.
- memWrite, input, 1, write request from control, sampled in IDLE.
- memGetData, input, 1, address select: 0 = pc (instruction), 1 = aluOut (data).
- irWrite, input, 1, sampled with memRead: 1 = read result goes to IR, 0 = read result goes to MDR.
- pc, input, ADDR_W, program counter.
- aluOut, input, ADDR_W, ALUOut register (load/store address).
- storeData, input, DATA_W, B register (store data).
- memReqValid, output, 1, request valid to memory.
- memReqReady, input, 1, memory accepts the request.
- memReqWrite, output, 1, 1 = write request.
- memReqAddr, output, ADDR_W, request address.
- memReqWdata, output, DATA_W, write data.
- memRespValid, input, 1, read data valid (single-cycle pulse).
- memRespData, input, DATA_W, read data.
- instr, output, DATA_W, Instruction Register.
- opcode, output, 7, instr[6:0]; feeds the control FSM.
- mdr, output, DATA_W, Memory Data Register.
- stall, output, 1, port busy; control holds its state while high.
- err, output, 1, sticky error flag: misalignment or timeout.

Behaviour:
- Reset (synchronous, active-high, overrides everything):
  - state = IDLE.
  - instr = 0, mdr = 0, memReqValid = 0, memReqWrite = 0, memReqAddr = 0, memReqWdata = 0, err = 0, timeout counter = 0.
  - Reset during REQ or WAIT aborts the transaction. A memRespValid arriving after reset is ignored.
- States: IDLE, REQ, WAIT.
- stall = (state != IDLE), combinational.
- IDLE:
  - On memRead or memWrite, latch the address: memGetData ? aluOut : pc.
  - Latch the kind (write when memWrite), the IR/MDR target (irWrite), and storeData.
  - If address[1:0] != 0: set err, issue no request, stay IDLE.
  - Otherwise go to REQ with memReqValid = 1 in the next cycle.
- Simultaneous memRead and memWrite: set err, issue no request, stay IDLE.
- REQ:
  - memReqValid held high. Address, data and write flag are held stable until memReqReady.
  - On ready with a write: go to IDLE (posted write; no response expected).
  - On ready with a read: go to WAIT.
- WAIT:
  - On memRespValid, load memRespData into instr (if the latched irWrite was set) or into mdr, then go to IDLE.
  - instr and mdr never change except on this edge (or reset).
- Timeout:
  - A counter clears on entry to REQ and on REQ->WAIT, and increments each cycle in REQ or WAIT.
  - When it reaches TIMEOUT: set err, return to IDLE, leave instr and mdr unchanged.
- Requests arriving while state != IDLE are ignored; control must hold them until stall falls.
- memRespValid seen in IDLE or REQ is ignored.
- Latency with zero-wait memory: request sampled at edge N; valid at N+1; ready in N+1 gives WAIT at N+2; response in N+2 gives IR/MDR updated and stall low at N+3.
- err stays set until reset.

Decomposition:
- Package mem_port_pkg holds:
  - state encoding (IDLE = 2'd0, REQ = 2'd1, WAIT = 2'd2);
  - RISC-V opcode constants shared with the control FSM (e.g. LOAD = 7'b0000011, STORE = 7'b0100011, OP = 7'b0110011, OP_IMM = 7'b0010011, BRANCH = 7'b1100011, JAL = 7'b1101111);
  - ADDR_W/DATA_W defaults.
- One natural sub-module: mem_port_timeout, the saturating counter with clear/enable inputs and an expired output.

Test Plan:
- Fetch, zero-wait memory: pc = 0x100, memRead = 1, irWrite = 1, memGetData = 0 at edge N.
  - Required: memReqAddr = 0x100, memReqWrite = 0 at N+1.
  - Ready at N+1, response 0x00A00093 at N+2.
  - At N+3: instr = 0x00A00093, opcode = 7'h13, stall = 0, mdr unchanged.
- Load with back-pressure: aluOut = 0x200, memGetData = 1, irWrite = 0; ready delayed 3 cycles, then response 0xDEADBEEF.
  - memReqValid and memReqAddr stay stable throughout.
  - mdr = 0xDEADBEEF; instr unchanged; stall high for exactly 6 cycles.
- Store: aluOut = 0x204, storeData = 0x12345678, memWrite = 1.
  - One accepted request with memReqWrite = 1 and memReqWdata = 0x12345678.
  - Returns to IDLE the cycle after ready; IR and MDR unchanged.
- Misaligned access: memRead with aluOut = 0x202 → err = 1, memReqValid never asserts, stall stays 0.
- Timeout with TIMEOUT = 8: memory never asserts memRespValid → err = 1 and stall = 0 after 8 cycles in WAIT.
  - A late memRespValid is then ignored; mdr unchanged.
- Reset mid-WAIT: assert reset for 1 cycle → state IDLE, all outputs at reset values; a response one cycle later does not update instr.
